// File: rtl/seg7_share_arbiter_if.sv
// Requester/display bus between the requesters and the 7-segment share arbiter.
// master = requester side (drives REQ/VAL), slave = arbiter side (drives grant and display).
interface seg7_share_arbiter_if;
  logic [2:0]  REQ;
  logic [15:0] VAL0;
  logic [15:0] VAL1;
  logic [15:0] VAL2;
  logic [2:0]  GNT;
  logic [3:0]  D1;
  logic [3:0]  D2;
  logic [3:0]  D3;
  logic [3:0]  D4;
  logic        BLANK;
  logic        SWITCH;

  modport master (
    output REQ, VAL0, VAL1, VAL2,
    input  GNT, D1, D2, D3, D4, BLANK, SWITCH
  );

  modport slave (
    input  REQ, VAL0, VAL1, VAL2,
    output GNT, D1, D2, D3, D4, BLANK, SWITCH
  );
endinterface

// File: rtl/seg7_share_arbiter.sv
// Round-robin sharing of the 4-digit 7-segment display among 3 requesters,
// with a minimum on-screen hold time per grantee.
module seg7_share_arbiter #(
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 26
) (
  input logic                  CLK,
  input logic                  CLR,
  seg7_share_arbiter_if.slave  bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  logic [0:0]       state_q, state_n;
  logic [2:0]       gnt_q, gnt_n;
  logic [1:0]       last_q, last_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [15:0]      d_q, d_n;
  logic             blank_q, blank_n;
  logic             switch_q, switch_n;
  logic [2:0]       win;

  // First set bit of req, scanning from last+1 (mod 3).
  function automatic logic [2:0] rr_pick(input logic [2:0] req, input logic [1:0] last);
    logic [2:0] pick;
    logic [2:0] sum;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 1; k <= 3; k++) begin
      sum = 3'(last) + 3'(k);
      idx = (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
      if (pick == 3'b000 && req[idx]) pick[idx] = 1'b1;
    end
    return pick;
  endfunction

  function automatic logic [1:0] enc(input logic [2:0] onehot);
    if (onehot[1])      return 2'd1;
    else if (onehot[2]) return 2'd2;
    else                return 2'd0;
  endfunction

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= IDLE;
      gnt_q    <= 3'b000;
      last_q   <= 2'd2;
      cnt_q    <= '0;
      d_q      <= 16'h0000;
      blank_q  <= 1'b1;
      switch_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      gnt_q    <= gnt_n;
      last_q   <= last_n;
      cnt_q    <= cnt_n;
      d_q      <= d_n;
      blank_q  <= blank_n;
      switch_q <= switch_n;
    end
  end

  always_comb begin
    state_n = state_q;
    gnt_n   = gnt_q;
    last_n  = last_q;
    cnt_n   = cnt_q;
    win     = 3'b000;
    case (state_q)
      IDLE: begin
        win = rr_pick(bus.REQ, last_q);
        if (win != 3'b000) begin
          gnt_n   = win;
          last_n  = enc(win);
          cnt_n   = CNT_RELOAD;
          state_n = HOLD;
        end else begin
          gnt_n = 3'b000;
        end
      end
      HOLD: begin
        if ((bus.REQ & gnt_q) == 3'b000) begin
          gnt_n   = 3'b000;
          state_n = IDLE;
        end else if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          // last_q equals the grantee here, so the scan starts at the next requester.
          win = rr_pick(bus.REQ & ~gnt_q, last_q);
          if (win != 3'b000) begin
            gnt_n  = win;
            last_n = enc(win);
          end
          cnt_n = CNT_RELOAD;
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = 3'b000;
      end
    endcase

    blank_n  = (gnt_n == 3'b000);
    switch_n = (gnt_n != gnt_q);
    // Nibbles track the next grantee so they land on the same edge as GNT.
    if (gnt_n[0])      d_n = bus.VAL0;
    else if (gnt_n[1]) d_n = bus.VAL1;
    else if (gnt_n[2]) d_n = bus.VAL2;
    else               d_n = 16'h0000;
  end

  assign bus.GNT    = gnt_q;
  assign bus.D1     = d_q[3:0];
  assign bus.D2     = d_q[7:4];
  assign bus.D3     = d_q[11:8];
  assign bus.D4     = d_q[15:12];
  assign bus.BLANK  = blank_q;
  assign bus.SWITCH = switch_q;

endmodule
